// File: rtl/sine_pwm.sv
// Sine PWM modulator: a free-running CNT_W-bit counter compared against a duty value that is
// refreshed once per PWM period from a single-entry shadow buffer fed by the sine LUT reader.
// DATA_W must equal CNT_W; duty and counter are compared as plain unsigned values.
module sine_pwm #(
  parameter int unsigned CNT_W  = 10,
  parameter int unsigned DATA_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              data_valid,
  input  logic [DATA_W-1:0] pwm_sin_val,
  output logic              pwm_out,
  output logic              period_start,
  output logic              sample_req,
  output logic              underrun,
  output logic              overrun,
  output logic              busy
);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] duty_q, duty_d;
  logic [DATA_W-1:0] shadow_q, shadow_d;
  logic              shadow_full_q, shadow_full_d;
  logic              pwm_q, pwm_d;
  logic              underrun_q, underrun_d;
  logic              overrun_q, overrun_d;

  logic              wrap;
  logic              load;

  // Next-state logic: FSM, counter, shadow buffer, duty reload and sticky flags.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    duty_d        = duty_q;
    shadow_d      = shadow_q;
    shadow_full_d = shadow_full_q;
    underrun_d    = underrun_q;
    overrun_d     = overrun_q;

    wrap = (state_q == StRun) && (cnt_q == '1);
    // A new period begins next cycle: first RUN cycle, or a wrap while still enabled.
    load = enable && ((state_q == StIdle) || wrap);

    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (enable) state_d = StRun;
      end
      StRun: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (wrap && !enable) state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase

    if (data_valid) begin
      shadow_d      = pwm_sin_val;
      shadow_full_d = 1'b1;
      // Overwriting an unconsumed sample loses it, unless this cycle's reload takes the new one.
      if (shadow_full_q && !load) overrun_d = 1'b1;
    end

    if (load) begin
      if (data_valid) begin
        duty_d = pwm_sin_val;
      end else if (shadow_full_q) begin
        duty_d = shadow_q;
      end else begin
        underrun_d = 1'b1;
      end
      shadow_full_d = 1'b0;
    end

    pwm_d = (state_q == StRun) && (cnt_q < duty_q);
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      duty_q        <= '0;
      shadow_q      <= '0;
      shadow_full_q <= 1'b0;
      pwm_q         <= 1'b0;
      underrun_q    <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      duty_q        <= duty_d;
      shadow_q      <= shadow_d;
      shadow_full_q <= shadow_full_d;
      pwm_q         <= pwm_d;
      underrun_q    <= underrun_d;
      overrun_q     <= overrun_d;
    end
  end

  // Outputs decoded from registered state; sample_req also fires in the IDLE->RUN cycle.
  always_comb begin
    busy         = (state_q == StRun);
    period_start = busy && (cnt_q == '0);
    sample_req   = !reset && (period_start || ((state_q == StIdle) && enable));
    pwm_out      = pwm_q;
    underrun     = underrun_q;
    overrun      = overrun_q;
  end

endmodule

// File: tb/tb_sine_pwm.sv
// Self-checking bench for sine_pwm: per-period high-cycle counts are queued as each scenario is
// set up and compared by a monitor over the 1024 cycles that follow every period_start.
module tb_sine_pwm;

  localparam int CNT_W  = 10;
  localparam int PERIOD = 1 << CNT_W;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             enable = 1'b0;
  logic             data_valid = 1'b0;
  logic [CNT_W-1:0] pwm_sin_val = '0;
  logic             pwm_out, period_start, sample_req, underrun, overrun, busy;

  int n_checks = 0;
  int n_pass   = 0;
  int exp_q[$];

  bit win_active = 1'b0;
  int win_left   = 0;
  int win_hi     = 0;
  int win_exp    = 0;

  sine_pwm #(
    .CNT_W  (CNT_W),
    .DATA_W (CNT_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .data_valid   (data_valid),
    .pwm_sin_val  (pwm_sin_val),
    .pwm_out      (pwm_out),
    .period_start (period_start),
    .sample_req   (sample_req),
    .underrun     (underrun),
    .overrun      (overrun),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  // pwm_out lags cnt by one clock, so a period's waveform spans the 1024 cycles after period_start.
  always @(negedge clk) begin
    if (win_active) begin
      win_hi += int'(pwm_out === 1'b1);
      win_left--;
      if (win_left == 0) begin
        win_active = 1'b0;
        n_checks++;
        if (win_hi !== win_exp)
          $display("FAIL period_high: got %0d high cycles, required %0d", win_hi, win_exp);
        else n_pass++;
      end
    end
    if (period_start === 1'b1 && exp_q.size() > 0) begin
      win_active = 1'b1;
      win_left   = PERIOD;
      win_hi     = 0;
      win_exp    = exp_q.pop_front();
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_ps(input string tag, output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (period_start !== 1'b1 && cyc < 3000);
    if (period_start !== 1'b1) begin
      n_checks++;
      $display("FAIL %s_timeout: no period_start within %0d cycles", tag, cyc);
    end
  endtask

  task automatic apply_reset();
    reset = 1'b1; enable = 1'b0; data_valid = 1'b0;
    step(2);
    reset = 1'b0;
  endtask

  task automatic pulse_dv(input int val);
    data_valid = 1'b1; pwm_sin_val = CNT_W'(val);
    step(1);
    data_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b1; data_valid = 1'b1; pwm_sin_val = CNT_W'(999);
    step(3);
    n_checks++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b, required 0", busy); else n_pass++;
    n_checks++; if (pwm_out !== 1'b0) $display("FAIL rst_pwm: got %b, required 0", pwm_out);
    else n_pass++;
    n_checks++; if (period_start !== 1'b0) $display("FAIL rst_ps: got %b, required 0", period_start);
    else n_pass++;
    n_checks++; if (sample_req !== 1'b0) $display("FAIL rst_req: got %b, required 0", sample_req);
    else n_pass++;
    n_checks++; if (underrun !== 1'b0) $display("FAIL rst_ur: got %b, required 0", underrun);
    else n_pass++;
    n_checks++; if (overrun !== 1'b0) $display("FAIL rst_or: got %b, required 0", overrun);
    else n_pass++;
    reset = 1'b0; enable = 1'b0; data_valid = 1'b0;
    step(5);
    n_checks++; if (busy !== 1'b0) $display("FAIL idle_busy: got %b, required 0", busy); else n_pass++;
    n_checks++; if (sample_req !== 1'b0) $display("FAIL idle_req: got %b, required 0", sample_req);
    else n_pass++;
    enable = 1'b1;
    #1;
    n_checks++; if (sample_req !== 1'b1) $display("FAIL start_req: got %b, required 1", sample_req);
    else n_pass++;
    step(1);
    n_checks++; if (busy !== 1'b1) $display("FAIL start_busy: got %b, required 1", busy); else n_pass++;
    n_checks++; if (period_start !== 1'b1) $display("FAIL start_ps: got %b, required 1", period_start);
    else n_pass++;
    // The sample offered during reset must have been ignored, so the first period underruns.
    n_checks++; if (underrun !== 1'b1) $display("FAIL start_ur: got %b, required 1", underrun);
    else n_pass++;
    step(1);
    n_checks++; if (period_start !== 1'b0) $display("FAIL ps_pulse: got %b, required 0", period_start);
    else n_pass++;
  endtask

  task automatic test_steady();
    int cyc;
    apply_reset();
    pulse_dv(256);
    repeat (3) exp_q.push_back(256);
    enable = 1'b1;
    step(1);
    for (int p = 0; p < 3; p++) begin
      step(5);
      pulse_dv(256);
      wait_ps("steady", cyc);
      n_checks++;
      if (cyc + 6 !== PERIOD) $display("FAIL steady_interval: got %0d cycles, required %0d", cyc + 6, PERIOD);
      else n_pass++;
    end
    n_checks++; if (underrun !== 1'b0) $display("FAIL steady_ur: got %b, required 0", underrun);
    else n_pass++;
    n_checks++; if (overrun !== 1'b0) $display("FAIL steady_or: got %b, required 0", overrun);
    else n_pass++;
  endtask

  task automatic test_extremes();
    int cyc;
    apply_reset();
    pulse_dv(0);
    exp_q.push_back(0);
    exp_q.push_back(1023);
    enable = 1'b1;
    step(1);
    step(5);
    pulse_dv(1023);
    wait_ps("extremes", cyc);
    step(5);
    pulse_dv(1023);
    wait_ps("extremes", cyc);
    n_checks++; if (underrun !== 1'b0) $display("FAIL extremes_ur: got %b, required 0", underrun);
    else n_pass++;
  endtask

  task automatic test_overrun();
    int cyc;
    apply_reset();
    pulse_dv(100);
    exp_q.push_back(100);
    exp_q.push_back(200);
    enable = 1'b1;
    step(1);
    step(5);
    pulse_dv(100);
    n_checks++; if (overrun !== 1'b0) $display("FAIL or_first: got %b, required 0", overrun);
    else n_pass++;
    step(3);
    pulse_dv(200);
    n_checks++; if (overrun !== 1'b1) $display("FAIL or_second: got %b, required 1", overrun);
    else n_pass++;
    wait_ps("overrun", cyc);
    wait_ps("overrun", cyc);
    n_checks++; if (overrun !== 1'b1) $display("FAIL or_sticky: got %b, required 1", overrun);
    else n_pass++;
  endtask

  task automatic test_underrun();
    int cyc;
    apply_reset();
    pulse_dv(512);
    exp_q.push_back(512);
    exp_q.push_back(512);
    enable = 1'b1;
    step(1);
    step(500);
    n_checks++; if (underrun !== 1'b0) $display("FAIL ur_early: got %b, required 0", underrun);
    else n_pass++;
    wait_ps("underrun", cyc);
    n_checks++; if (underrun !== 1'b1) $display("FAIL ur_set: got %b, required 1", underrun);
    else n_pass++;
    wait_ps("underrun", cyc);
  endtask

  task automatic test_bypass();
    int cyc;
    apply_reset();
    pulse_dv(50);
    exp_q.push_back(50);
    exp_q.push_back(300);
    enable = 1'b1;
    step(1);
    step(5);
    pulse_dv(77);
    step(PERIOD - 1 - 6);
    n_checks++; if (period_start !== 1'b0) $display("FAIL byp_pre: got %b, required 0", period_start);
    else n_pass++;
    pulse_dv(300);
    n_checks++; if (period_start !== 1'b1) $display("FAIL byp_ps: got %b, required 1", period_start);
    else n_pass++;
    n_checks++; if (overrun !== 1'b0) $display("FAIL byp_or: got %b, required 0", overrun);
    else n_pass++;
    wait_ps("bypass", cyc);
    // The bypass emptied the shadow, so the following period has nothing to load.
    n_checks++; if (underrun !== 1'b1) $display("FAIL byp_ur: got %b, required 1", underrun);
    else n_pass++;
  endtask

  task automatic test_enable_drop();
    apply_reset();
    pulse_dv(400);
    exp_q.push_back(400);
    enable = 1'b1;
    step(1);
    step(500);
    enable = 1'b0;
    step(PERIOD - 1 - 500);
    n_checks++; if (busy !== 1'b1) $display("FAIL drop_finish: got %b, required 1", busy); else n_pass++;
    step(1);
    n_checks++; if (busy !== 1'b0) $display("FAIL drop_idle: got %b, required 0", busy); else n_pass++;
    n_checks++; if (period_start !== 1'b0) $display("FAIL drop_ps: got %b, required 0", period_start);
    else n_pass++;
    step(10);
    n_checks++; if (sample_req !== 1'b0) $display("FAIL drop_req: got %b, required 0", sample_req);
    else n_pass++;
    data_valid = 1'b1; pwm_sin_val = CNT_W'(1000); enable = 1'b1;
    step(1);
    data_valid = 1'b0;
    step(10);
    data_valid = 1'b1; pwm_sin_val = CNT_W'(900);
    step(2);
    data_valid = 1'b0;
    step(700 - 12);
    n_checks++; if (pwm_out !== 1'b1) $display("FAIL run2_pwm: got %b, required 1", pwm_out);
    else n_pass++;
    n_checks++; if (overrun !== 1'b1) $display("FAIL run2_or: got %b, required 1", overrun);
    else n_pass++;
    reset = 1'b1;
    step(1);
    n_checks++; if (pwm_out !== 1'b0) $display("FAIL abort_pwm: got %b, required 0", pwm_out);
    else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL abort_busy: got %b, required 0", busy); else n_pass++;
    n_checks++; if (overrun !== 1'b0) $display("FAIL abort_or: got %b, required 0", overrun);
    else n_pass++;
    n_checks++; if (underrun !== 1'b0) $display("FAIL abort_ur: got %b, required 0", underrun);
    else n_pass++;
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_steady();
    test_extremes();
    test_overrun();
    test_underrun();
    test_bypass();
    test_enable_drop();
    step(2);
    n_checks++;
    if (exp_q.size() != 0 || win_active)
      $display("FAIL scoreboard_drain: got %0d pending, required 0", exp_q.size() + int'(win_active));
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sine_pwm.md
SINE_PWM -- requirements
Module: sine_pwm

Interface
REQ-001 SHALL have parameter CNT_W, default 10, the PWM counter width; PWM period = 2^CNT_W clk cycles.
REQ-002 SHALL have parameter DATA_W, default 10, the sample width; DATA_W SHALL equal CNT_W.
REQ-003 SHALL have port clk, input, 1, the single rising-edge clock for all state.
REQ-004 SHALL have port reset, input, 1, the reset; it is synchronous and active-high.
REQ-005 SHALL have port enable, input, 1, the run request.
REQ-006 SHALL have port data_valid, input, 1, which qualifies pwm_sin_val for one cycle.
REQ-007 SHALL have port pwm_sin_val, input, DATA_W, the unsigned duty sample from the sine LUT reader.
REQ-008 SHALL have port pwm_out, output, 1, the registered PWM waveform.
REQ-009 SHALL have port period_start, output, 1, a one-cycle pulse on the first cycle of each PWM period.
REQ-010 SHALL have port sample_req, output, 1, a one-cycle pulse requesting the next sample.
REQ-011 SHALL have port underrun, output, 1, a sticky flag: the period started with no new sample.
REQ-012 SHALL have port overrun, output, 1, a sticky flag: a buffered sample was overwritten before use.
REQ-013 SHALL have port busy, output, 1, high while the FSM is in RUN.

Function
REQ-014 SHALL implement FSM states IDLE and RUN.
REQ-015 SHALL move IDLE->RUN on the first clk with enable=1; cnt SHALL start at 0 in the next cycle.
REQ-016 SHALL, in RUN, increment cnt by 1 per clk, modulo 2^CNT_W; wrap from all-ones to 0 is a period boundary.
REQ-017 SHALL move RUN->IDLE only at a period boundary with enable=0; an enable drop mid-period finishes the current period.
REQ-018 SHALL, in IDLE, hold cnt=0 and pwm_out=0, and pulse neither period_start nor sample_req.
REQ-019 SHALL hold a shadow register plus a shadow_full bit; data_valid=1 loads shadow and sets shadow_full in any state.
REQ-020 SHALL set overrun when data_valid=1 while shadow_full=1 and no boundary occurs that cycle; the new value replaces the old.
REQ-021 SHALL update duty_active at each period start (cnt going to 0, including the first cycle of RUN) from these sources, in priority order:
- data_valid=1 that same cycle: use pwm_sin_val directly;
- else shadow_full=1: use shadow;
- else: keep the previous duty_active and set underrun.
REQ-022 SHALL clear shadow_full whenever a load under REQ-021 consumes it or bypasses it.
REQ-023 SHALL drive pwm_out <= (cnt < duty_active) in RUN, registered, so pwm_out lags cnt by one clk.
REQ-024 SHALL produce these duty extremes: duty 0 gives constant low; duty 2^CNT_W-1 gives low for exactly 1 cycle per period.
REQ-025 SHALL compare cnt and duty_active as unsigned values; there is no saturation or scaling.
REQ-026 SHALL pulse period_start in the cycle cnt=0 in RUN.
REQ-027 SHALL pulse sample_req in the same cycle as period_start, and also in the first IDLE->RUN transition cycle.
REQ-028 SHALL clear underrun and overrun only by reset.

Reset
REQ-029 SHALL, on reset=1 at a clk edge, set:
- state=IDLE, cnt=0, duty_active=0;
- shadow=0, shadow_full=0;
- pwm_out=0, period_start=0, sample_req=0;
- underrun=0, overrun=0, busy=0.
REQ-030 SHALL give reset priority over enable and data_valid; reset mid-period aborts the period immediately.
REQ-031 SHALL, after reset deasserts, stay in IDLE until enable=1.

Verification
REQ-032 SHALL cover this scenario: sample 256 with data_valid, then enable=1 -> each period gives 256 high + 768 low cycles; period_start every 1024 clk; underrun=0.
REQ-033 SHALL cover this scenario: samples 0, then 1023 -> period 1 all low; period 2 has 1023 high + 1 low.
REQ-034 SHALL cover this scenario: samples 100 then 200 in one period, no boundary between -> next period uses 200; overrun=1.
REQ-035 SHALL cover this scenario: no data_valid for one full period after a 512 sample -> next period repeats 512; underrun=1.
REQ-036 SHALL cover this scenario: data_valid with 300 in the same cycle cnt wraps to 0 -> that period uses 300; shadow_full=0; overrun stays 0.
REQ-037 SHALL cover this scenario: enable=0 at cnt=500, then reset at cnt=700 of the next run -> the first period completes, then IDLE; reset forces pwm_out=0, busy=0 and flags=0 on the next cycle.
